stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the data width of all data ports.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The module SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-005 The module SHALL have port in_sel, input, 1 bit: the route select; 1 routes to channel 1, 0 routes to channel 2.
REQ-006 The module SHALL have port in_valid, input, 1 bit: the upstream offers in_data/in_sel.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the block accepts the current offer.
REQ-008 The module SHALL have port out1_data, output, WIDTH bits: the channel-1 payload.
REQ-009 The module SHALL have port out1_valid, output, 1 bit: channel 1 holds a word.
REQ-010 The module SHALL have port out1_ready, input, 1 bit: the channel-1 consumer takes the word.
REQ-011 The module SHALL have port out2_data, output, WIDTH bits: the channel-2 payload.
REQ-012 The module SHALL have port out2_valid, output, 1 bit: channel 2 holds a word.
REQ-013 The module SHALL have port out2_ready, input, 1 bit: the channel-2 consumer takes the word.
REQ-014 The module SHALL have port cnt1, output, 16 bits: the count of completed channel-1 output transfers.
REQ-015 The module SHALL have port cnt2, output, 16 bits: the count of completed channel-2 output transfers.

Function
REQ-016 An input transfer SHALL occur in a cycle where in_valid=1 and in_ready=1; an output transfer on channel k SHALL occur where outk_valid=1 and outk_ready=1.
REQ-017 Each channel SHALL hold a one-entry register with a two-state FSM, EMPTY and FULL, where outk_valid=1 if and only if the channel is FULL.
REQ-018 A channel SHALL transition EMPTY->FULL on an input transfer routed to it.
REQ-019 A channel SHALL transition FULL->EMPTY on an output transfer with no simultaneous routed input transfer.
REQ-020 A channel SHALL remain FULL, loading the new word, when an output transfer and a routed input transfer occur in the same cycle.
REQ-021 in_ready SHALL be combinational and SHALL equal (selected channel EMPTY) OR (selected channel FULL AND its outk_ready=1), where the selected channel is 1 when in_sel=1 and 2 when in_sel=0.
REQ-022 in_ready SHALL NOT depend on the state of the non-selected channel, so a stalled channel never blocks traffic to the other channel.
REQ-023 Latency SHALL be exactly one cycle: a word accepted at edge N SHALL be presented with outk_valid=1 after edge N.
REQ-024 outk_data SHALL hold stable while outk_valid=1 and outk_ready=0.
REQ-025 Words SHALL be delivered in acceptance order per channel, and no word SHALL be dropped or duplicated.
REQ-026 The channel-1 register SHALL load in_data only on accepted transfers with in_sel=1, and the channel-2 register only on accepted transfers with in_sel=0.
REQ-027 cnt1 and cnt2 SHALL each increment by 1 on every output transfer of their channel and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-028 Both channels SHALL be able to complete output transfers in the same cycle, each counter incrementing independently.
REQ-029 When in_valid=0, in_sel and in_data SHALL have no effect on any state.
REQ-030 Sustained throughput SHALL be one word per cycle per channel when the consumer holds ready=1.

Reset
REQ-031 While rst=1, regardless of clk, both channels SHALL be EMPTY, out1_valid=0, out2_valid=0, out1_data=0, out2_data=0, cnt1=0, and cnt2=0.
REQ-032 A reset asserted mid-operation SHALL discard any held words immediately, with no output transfer counted for them.
REQ-033 After rst deasserts, in_ready SHALL be 1 for either value of in_sel.

Verification
REQ-034 The bench SHALL cover basic routing: offer 32'hA5A5_0001 with sel=1, then 32'h0000_BEEF with sel=0, both outputs ready -> out1_data=A5A5_0001 one cycle after its accept, out2_data=0000_BEEF one cycle after its accept, and cnt1=cnt2=1.
REQ-035 The bench SHALL cover isolation: with out1_ready=0 and channel 1 FULL, offer sel=1 -> in_ready=0 and out1_data is unchanged; then offer sel=0 -> in_ready=1 and the word appears on channel 2.
REQ-036 The bench SHALL cover simultaneous drain and load: with channel 2 FULL (value 7), out2_ready=1, and a sel=0 offer of value 8 in the same cycle -> out2_valid stays 1, out2_data=8 next cycle, and cnt2 increments by 1.
REQ-037 The bench SHALL cover counter wrap: run 65537 channel-1 transfers back-to-back -> cnt1=1, no bubbles, and data in order.
REQ-038 The bench SHALL cover reset mid-operation: with both channels FULL, assert rst between clock edges -> both valids and data drop to 0 immediately, counters read 0, and in_ready=1 after release.
REQ-039 The bench SHALL cover random stress: random in_valid/in_sel/outk_ready over 10000 cycles against a scoreboard with two queues -> no loss, no duplication, per-channel order preserved, and counts match the scoreboard.

Source files
------------

// File: rtl/stream_demux.sv
// stream_demux: routes one valid/ready input stream to one of two output
// channels, each backed by a one-entry register (EMPTY/FULL FSM).
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_data, in_sel          - payload and route (1 -> channel 1, 0 -> channel 2)
//   in_valid, in_ready       - input handshake (in_ready is combinational)
//   out1_data/valid/ready    - channel-1 output handshake
//   out2_data/valid/ready    - channel-2 output handshake
//   cnt1, cnt2               - wrapping counts of completed output transfers
module stream_demux #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [15:0]      cnt1,
  output logic [15:0]      cnt2
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state1_q, state1_d;
  state_t state2_q, state2_d;

  logic accept;
  logic load1;
  logic load2;
  logic xfer1;
  logic xfer2;

  // Readiness looks only at the selected channel so a stalled channel
  // never blocks traffic bound for the other one.
  assign in_ready = in_sel ? ((state1_q == EMPTY) || out1_ready)
                           : ((state2_q == EMPTY) || out2_ready);

  assign accept = in_valid && in_ready;
  assign load1  = accept && in_sel;
  assign load2  = accept && !in_sel;
  assign xfer1  = (state1_q == FULL) && out1_ready;
  assign xfer2  = (state2_q == FULL) && out2_ready;

  assign out1_valid = (state1_q == FULL);
  assign out2_valid = (state2_q == FULL);

  // Channel state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state1_q <= EMPTY;
      state2_q <= EMPTY;
    end else begin
      state1_q <= state1_d;
      state2_q <= state2_d;
    end
  end

  // Channel next-state: a same-cycle drain and load keeps the channel FULL
  always_comb begin
    state1_d = state1_q;
    state2_d = state2_q;
    case (state1_q)
      EMPTY:   if (load1) state1_d = FULL;
      FULL:    if (xfer1 && !load1) state1_d = EMPTY;
      default: state1_d = EMPTY;
    endcase
    case (state2_q)
      EMPTY:   if (load2) state2_d = FULL;
      FULL:    if (xfer2 && !load2) state2_d = EMPTY;
      default: state2_d = EMPTY;
    endcase
  end

  // Payload registers load only on accepted words routed to them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out1_data <= '0;
      out2_data <= '0;
    end else begin
      if (load1) out1_data <= in_data;
      if (load2) out2_data <= in_data;
    end
  end

  // Output transfer counters, wrapping naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else begin
      if (xfer1) cnt1 <= cnt1 + CNT_W'(1);
      if (xfer2) cnt2 <= cnt2 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed and random checks for stream_demux.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out2_data;
  logic        out2_valid;
  logic        out2_ready;
  logic [15:0] cnt1;
  logic [15:0] cnt2;

  int checks = 0;
  int errors = 0;

  stream_demux #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .cnt1       (cnt1),
    .cnt2       (cnt2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    out1_ready = 1'b0; out2_ready = 1'b0;
    #2;
    checks++;
    if ({out1_valid, out2_valid, out1_data, out2_data, cnt1, cnt2} !== '0) begin
      errors++;
      $display("FAIL reset_state got v1=%b v2=%b d1=%h d2=%h c1=%0d c2=%0d want all 0",
               out1_valid, out2_valid, out1_data, out2_data, cnt1, cnt2);
    end
    step();
    rst = 1'b0;
    in_sel = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_sel1 got %b want 1", in_ready); end
    in_sel = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_sel0 got %b want 1", in_ready); end
  endtask

  task automatic test_routing();
    step();
    out1_ready = 1'b1; out2_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hA5A5_0001;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL route_ready got %b want 1", in_ready); end
    step();
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'hA5A5_0001) begin
      errors++; $display("FAIL route_ch1 got v=%b d=%h want v=1 d=a5a50001", out1_valid, out1_data);
    end
    in_sel = 1'b0; in_data = 32'h0000_BEEF;
    step();
    checks++;
    if (out2_valid !== 1'b1 || out2_data !== 32'h0000_BEEF) begin
      errors++; $display("FAIL route_ch2 got v=%b d=%h want v=1 d=0000beef", out2_valid, out2_data);
    end
    checks++;
    if (cnt1 !== 16'd1 || out1_valid !== 1'b0) begin
      errors++; $display("FAIL route_cnt1 got cnt1=%0d v1=%b want cnt1=1 v1=0", cnt1, out1_valid);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (cnt2 !== 16'd1 || out2_valid !== 1'b0) begin
      errors++; $display("FAIL route_cnt2 got cnt2=%0d v2=%b want cnt2=1 v2=0", cnt2, out2_valid);
    end
  endtask

  task automatic test_isolation();
    out1_ready = 1'b0; out2_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h0000_0111;
    step();
    in_data = 32'h0000_0222;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL iso_blocked got %b want 0", in_ready); end
    step();
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'h0000_0111) begin
      errors++; $display("FAIL iso_hold got v=%b d=%h want v=1 d=00000111", out1_valid, out1_data);
    end
    in_sel = 1'b0; in_data = 32'h0000_0333;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL iso_other_ready got %b want 1", in_ready); end
    step();
    checks++;
    if (out2_valid !== 1'b1 || out2_data !== 32'h0000_0333 || out1_data !== 32'h0000_0111) begin
      errors++; $display("FAIL iso_ch2 got v2=%b d2=%h d1=%h want v2=1 d2=00000333 d1=00000111",
                         out2_valid, out2_data, out1_data);
    end
    in_valid = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
    step();
    checks++;
    if (cnt1 !== 16'd2 || cnt2 !== 16'd2 || out1_valid !== 1'b0 || out2_valid !== 1'b0) begin
      errors++; $display("FAIL iso_dual_drain got c1=%0d c2=%0d v1=%b v2=%b want 2 2 0 0",
                         cnt1, cnt2, out1_valid, out2_valid);
    end
  endtask

  task automatic test_drain_load();
    out2_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd7;
    step();
    checks++;
    if (out2_valid !== 1'b1 || out2_data !== 32'd7) begin
      errors++; $display("FAIL dl_first got v=%b d=%h want v=1 d=7", out2_valid, out2_data);
    end
    out2_ready = 1'b1; in_data = 32'd8;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL dl_ready got %b want 1", in_ready); end
    step();
    checks++;
    if (out2_valid !== 1'b1 || out2_data !== 32'd8 || cnt2 !== 16'd3) begin
      errors++; $display("FAIL dl_swap got v=%b d=%h c2=%0d want v=1 d=8 c2=3", out2_valid, out2_data, cnt2);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out2_valid !== 1'b0 || cnt2 !== 16'd4) begin
      errors++; $display("FAIL dl_drain got v=%b c2=%0d want v=0 c2=4", out2_valid, cnt2);
    end
  endtask

  task automatic test_wrap();
    int bubbles;
    int order_bad;
    bubbles = 0; order_bad = 0;
    step();
    rst = 1'b1; #1; rst = 1'b0;
    out1_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_data = 32'(i);
      #1;
      if (in_ready !== 1'b1) bubbles++;
      step();
      if (out1_valid !== 1'b1 || out1_data !== 32'(i)) order_bad++;
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (bubbles != 0) begin errors++; $display("FAIL wrap_bubbles got %0d want 0", bubbles); end
    checks++;
    if (order_bad != 0) begin errors++; $display("FAIL wrap_order got %0d bad words want 0", order_bad); end
    checks++;
    if (cnt1 !== 16'd1 || cnt2 !== 16'd0 || out1_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_count got c1=%0d c2=%0d v1=%b want 1 0 0", cnt1, cnt2, out1_valid);
    end
  endtask

  task automatic test_reset_mid();
    out1_ready = 1'b0; out2_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h0000_AAAA;
    step();
    in_sel = 1'b0; in_data = 32'h0000_BBBB;
    step();
    in_valid = 1'b0;
    checks++;
    if (out1_valid !== 1'b1 || out2_valid !== 1'b1) begin
      errors++; $display("FAIL rmid_full got v1=%b v2=%b want 1 1", out1_valid, out2_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out1_valid, out2_valid, out1_data, out2_data} !== '0) begin
      errors++; $display("FAIL rmid_drop got v1=%b v2=%b d1=%h d2=%h want all 0",
                         out1_valid, out2_valid, out1_data, out2_data);
    end
    checks++;
    if (cnt1 !== 16'd0 || cnt2 !== 16'd0) begin
      errors++; $display("FAIL rmid_cnt got c1=%0d c2=%0d want 0 0", cnt1, cnt2);
    end
    out1_ready = 1'b1; out2_ready = 1'b1;
    step();
    rst = 1'b0;
    in_sel = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_sel1 got %b want 1", in_ready); end
    in_sel = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1 || cnt1 !== 16'd0 || cnt2 !== 16'd0 || out1_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_release got rdy=%b c1=%0d c2=%0d v1=%b want 1 0 0 0",
                         in_ready, cnt1, cnt2, out1_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] w;
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic        exp_rdy;
    int          bad;
    exp1 = '0; exp2 = '0; bad = 0;
    for (int c = 0; c < 10001; c++) begin
      step();
      if (c < 10000) begin
        in_valid   = 1'($urandom_range(0, 1));
        in_sel     = 1'($urandom_range(0, 1));
        in_data    = $urandom();
        out1_ready = 1'($urandom_range(0, 1));
        out2_ready = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
      end
      #1;
      exp_rdy = in_sel ? ((q1.size() == 0) || out1_ready) : ((q2.size() == 0) || out2_ready);
      if (in_ready !== exp_rdy) bad++;
      if (out1_valid !== (q1.size() != 0)) bad++;
      if (out2_valid !== (q2.size() != 0)) bad++;
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) bad++;
        else begin w = q1.pop_front(); if (out1_data !== w) bad++; end
        exp1 = exp1 + 16'd1;
      end
      if (out2_valid && out2_ready) begin
        if (q2.size() == 0) bad++;
        else begin w = q2.pop_front(); if (out2_data !== w) bad++; end
        exp2 = exp2 + 16'd1;
      end
      if (in_valid && in_ready) begin
        if (in_sel) q1.push_back(in_data);
        else        q2.push_back(in_data);
      end
    end
    step();
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rand_scoreboard got %0d discrepancies want 0", bad); end
    checks++;
    if (cnt1 !== exp1) begin errors++; $display("FAIL rand_cnt1 got %0d want %0d", cnt1, exp1); end
    checks++;
    if (cnt2 !== exp2) begin errors++; $display("FAIL rand_cnt2 got %0d want %0d", cnt2, exp2); end
    checks++;
    if (out1_valid !== 1'b0 || out2_valid !== 1'b0 || q1.size() != 0 || q2.size() != 0) begin
      errors++; $display("FAIL rand_empty got v1=%b v2=%b q1=%0d q2=%0d want 0 0 0 0",
                         out1_valid, out2_valid, q1.size(), q2.size());
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_isolation();
    test_drain_load();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
